// File: rtl/rom_basic_ctrl_if.sv
// CPU-side bus between the 6502 core and the BASIC ROM controller.
// Valid/ready: the CPU presents addr/we only while cpu_clken is high, and it may run only while cpu_ready is high; read data is valid in any cycle where cpu_dvalid is high.
interface rom_basic_ctrl_if;
  logic        cpu_clken;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic        cpu_ready;
  logic        cpu_cs;
  logic [7:0]  cpu_dout;
  logic        cpu_dvalid;

  modport master (
    output cpu_clken, cpu_addr, cpu_we,
    input  cpu_ready, cpu_cs, cpu_dout, cpu_dvalid
  );

  modport slave (
    input  cpu_clken, cpu_addr, cpu_we,
    output cpu_ready, cpu_cs, cpu_dout, cpu_dvalid
  );
endinterface

// File: rtl/rom_basic_ctrl.sv
// Integer BASIC ROM controller: power-up checksum scan of the 4 KB ROM, then
// CPU read decoding with one-cycle registered read data and write flagging.
module rom_basic_ctrl #(
  parameter logic [15:0] BASE_ADDR  = 16'hE000,
  parameter bit          SELFTEST   = 1'b1,
  parameter logic [15:0] EXPECT_SUM = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  rom_basic_ctrl_if.slave   cpu,
  output logic [11:0]       rom_addr,
  input  logic [7:0]        rom_dout,
  output logic [15:0]       cksum,
  output logic              cksum_done,
  output logic              cksum_ok,
  output logic              wr_err,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t      state;
  logic [11:0] scan_addr;
  logic        pend;
  logic        rd_pend;
  logic        ready_q;
  logic        dvalid_q;
  logic [7:0]  dout_q;

  logic        cs;
  logic        rd_req;
  logic        wr_req;
  logic [15:0] sum_next;

  assign cs       = (cpu.cpu_addr[15:12] == BASE_ADDR[15:12]);
  assign rd_req   = (state == RUN) && cpu.cpu_clken && cs && !cpu.cpu_we;
  assign wr_req   = (state == RUN) && cpu.cpu_clken && cs && cpu.cpu_we;
  assign sum_next = cksum + {8'h00, rom_dout};

  // The ROM address follows the CPU bus combinationally once running so the
  // synchronous ROM captures the byte on the same edge as the strobe.
  assign rom_addr = (state == RUN) ? cpu.cpu_addr[11:0] : scan_addr;

  assign cpu.cpu_ready  = ready_q;
  assign cpu.cpu_cs     = cs;
  assign cpu.cpu_dout   = dout_q;
  assign cpu.cpu_dvalid = dvalid_q;
  assign fsm_state      = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SELFTEST ? SCAN : RUN;
      scan_addr  <= 12'h000;
      pend       <= 1'b0;
      rd_pend    <= 1'b0;
      cksum      <= 16'h0000;
      cksum_done <= !SELFTEST;
      cksum_ok   <= 1'b0;
      wr_err     <= 1'b0;
      ready_q    <= !SELFTEST;
      dout_q     <= 8'h00;
      dvalid_q   <= 1'b0;
    end else begin
      dvalid_q <= 1'b0;
      rd_pend  <= 1'b0;
      case (state)
        SCAN: begin
          // rom_dout holds the byte addressed on the previous edge.
          scan_addr <= scan_addr + 12'd1;
          pend      <= 1'b1;
          if (pend) cksum <= sum_next;
          if (scan_addr == 12'hFFF) state <= DRAIN;
        end
        DRAIN: begin
          cksum      <= sum_next;
          cksum_done <= 1'b1;
          cksum_ok   <= (sum_next == EXPECT_SUM);
          ready_q    <= 1'b1;
          pend       <= 1'b0;
          state      <= RUN;
        end
        RUN: begin
          rd_pend <= rd_req;
          if (rd_pend) begin
            dout_q   <= rom_dout;
            dvalid_q <= 1'b1;
          end
          if (wr_req) wr_err <= 1'b1;
        end
        default: state <= SELFTEST ? SCAN : RUN;
      endcase
    end
  end

endmodule

// File: doc/rom_basic_ctrl.md
# rom_basic_ctrl

CPU-side controller for the 4 KB Integer BASIC ROM, sitting between the 6502 bus and the synchronous ROM (12-bit address in, registered 8-bit data out one cycle later). After reset it runs a self-test that sums all 4096 ROM bytes and holds the CPU off until the sum is known. In run mode it decodes the BASIC window, drives the ROM address from the CPU bus, and captures and holds read data across the CPU's clock-enable cycle. It also flags any write into the ROM window.

## Interface
Parameters:
- BASE_ADDR, 16'hE000, base of the BASIC window; only bits [15:12] are decoded.
- SELFTEST, 1, 1 = run the checksum scan after reset; 0 = enter RUN directly.
- EXPECT_SUM, 16'h0000, golden 16-bit byte sum of the ROM image.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- cpu_clken  in  1  one-cycle CPU bus strobe; address and we are valid while high.
- cpu_addr  in  16  CPU address bus.
- cpu_we  in  1  CPU write strobe, qualified by cpu_clken.
- cpu_ready  out  1  high once the CPU may run; low during the scan.
- cpu_cs  out  1  combinational; high when cpu_addr[15:12] == BASE_ADDR[15:12].
- cpu_dout  out  8  captured ROM read data; holds until the next capture.
- cpu_dvalid  out  1  one-cycle pulse when cpu_dout is updated.
- rom_addr  out  12  address to the ROM.
- rom_dout  in  8  ROM data; registered, so valid one cycle after rom_addr.
- cksum  out  16  running or final byte sum.
- cksum_done  out  1  high once the scan has completed (sticky until reset).
- cksum_ok  out  1  cksum == EXPECT_SUM; meaningful only when cksum_done = 1.
- wr_err  out  1  sticky; set by any CPU write into the window.

## Operation
- FSM states: SCAN, DRAIN, RUN.
  - Reset enters SCAN if SELFTEST = 1, otherwise RUN.
- SCAN:
  - rom_addr = scan_addr (12-bit counter, 0 to 4095).
  - scan_addr increments every cycle.
  - A pending flag marks that a read was issued; on the following cycle cksum += {8'h00, rom_dout}, wrapping mod 2^16.
  - When scan_addr = 4095 has been issued, go to DRAIN.
- DRAIN: accumulate the final byte. Set cksum_done = 1 and cksum_ok = (final sum == EXPECT_SUM). Go to RUN.
- RUN:
  - cpu_ready = 1.
  - rom_addr = cpu_addr[11:0], combinational mux.
  - Read (cpu_clken & cpu_cs & ~cpu_we): set rd_pend. On the next edge, cpu_dout <= rom_dout and cpu_dvalid = 1 for one cycle.
  - Back-to-back reads on consecutive cycles pipeline: one dvalid per read, each arriving one cycle after its request.
  - Write (cpu_clken & cpu_cs & cpu_we): ROM is untouched; wr_err <= 1.
  - Accesses outside the window are ignored: no dvalid, no state change.
- cpu_clken while not in RUN is ignored; it produces no dvalid and no wr_err.
- RUN is terminal; only rst leaves it.
- Reset mid-scan: the scan restarts from address 0 with cksum = 0.
- Reset mid-read: the pending read is dropped; no dvalid is produced.

## Timing
- Reset values (all outputs and state):
  - cpu_ready = ~SELFTEST.
  - cpu_dout = 8'h00.
  - cpu_dvalid = 0.
  - cksum = 16'h0000.
  - cksum_done = 0 (1 if SELFTEST = 0).
  - cksum_ok = 0.
  - wr_err = 0.
  - scan_addr = 0.
  - rom_addr = 0.
- Edge count N starts at N = 1, the first rising edge with rst sampled low.
- Scan timeline:
  - Edge N = k (1 ≤ k ≤ 4096): the ROM captures byte k−1.
  - Edge 4096: FSM goes to DRAIN.
  - Edge 4097: last byte added; cksum_done, cksum_ok and cpu_ready all go high after this edge.
  - Total self-test: 4097 cycles.
- Read latency: strobe at edge E is captured by the ROM at edge E. cpu_dout and cpu_dvalid update at edge E+1 and are visible in the following cycle.
- cksum is stable from DRAIN onward.

## Test plan
- SELFTEST = 1, ROM image all 8'h01, EXPECT_SUM = 16'h1000 → cpu_ready low for exactly 4097 cycles after reset release; then cksum = 16'h1000, cksum_done = 1, cksum_ok = 1.
- ROM byte i = i[7:0], EXPECT_SUM = 16'h0000 → cksum = 16'hF800 (wrap check), cksum_ok = 0, cpu_ready still rises.
- RUN: reads at 16'hE000, then 16'hEFFF on consecutive clken cycles → two dvalid pulses, each one cycle after its strobe, carrying bytes 0 and 4095. cpu_dout holds the last byte afterwards.
- Read at 16'hD010 and write at 16'hE123 → no dvalid for either; cpu_dout unchanged; wr_err = 1 and stays set.
- rst asserted at cycle 2000 of the scan → after release, cksum restarts at 0; done occurs 4097 cycles after the new release with the same final sum as an uninterrupted scan.
- SELFTEST = 0 → cpu_ready = 1 and cksum_done = 1 directly out of reset; a read at 16'hE000 returns byte 0 with 1-cycle latency.
